reg_writeback_queue: RTL

REG_WRITEBACK_QUEUE -- requirements
Module: reg_writeback_queue

---
 rtl/reg_writeback_queue.sv | 110 +++++++++++
 1 files changed

// File: rtl/reg_writeback_queue.sv
// Writeback queue between execute results and the register file: drains one entry
// per cycle in arrival order and exposes youngest-match forwarding and a pending mask.
module reg_writeback_queue #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned DW    = 32,
    parameter int unsigned AW    = 5
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [AW-1:0]           in_addr,
    input  logic [DW-1:0]           in_data,
    output logic                    rf_we,
    output logic [AW-1:0]           rf_wa,
    output logic [DW-1:0]           rf_wd,
    input  logic [AW-1:0]           q_ra1,
    input  logic [AW-1:0]           q_ra2,
    output logic                    fwd1_hit,
    output logic                    fwd2_hit,
    output logic [DW-1:0]           fwd1_data,
    output logic [DW-1:0]           fwd2_data,
    output logic [(1<<AW)-1:0]      pending,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic [AW-1:0] addr_q [DEPTH];
    logic [AW-1:0] addr_d [DEPTH];
    logic [DW-1:0] data_q [DEPTH];
    logic [DW-1:0] data_d [DEPTH];
    logic          push;
    logic          pop;

    assign in_ready = (count_q < CW'(DEPTH));
    assign rf_we    = (count_q != '0);
    assign rf_wa    = addr_q[head_q];
    assign rf_wd    = data_q[head_q];
    assign count    = count_q;

    // Writes to r0 complete the handshake but never occupy an entry.
    always_comb begin
        push    = in_valid && in_ready && (in_addr != '0) && !reset;
        pop     = (count_q != '0);
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        addr_d  = addr_q;
        data_d  = data_q;
        if (push) begin
            addr_d[tail_q] = in_addr;
            data_d[tail_q] = in_data;
            tail_d         = tail_q + PW'(1);
        end
        if (pop) begin
            head_d = head_q + PW'(1);
        end
        count_d = count_q + CW'(push) - CW'(pop);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry storage carries no reset; validity comes from head/count alone.
    always_ff @(posedge clk) begin
        addr_q <= addr_d;
        data_q <= data_d;
    end

    // Scan oldest to youngest so the last match seen is the youngest.
    always_comb begin
        logic [PW-1:0] idx;
        fwd1_hit  = 1'b0;
        fwd2_hit  = 1'b0;
        fwd1_data = '0;
        fwd2_data = '0;
        pending   = '0;
        idx       = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            idx = head_q + PW'(i);
            if (CW'(i) < count_q) begin
                pending[addr_q[idx]] = 1'b1;
                if ((q_ra1 != '0) && (addr_q[idx] == q_ra1)) begin
                    fwd1_hit  = 1'b1;
                    fwd1_data = data_q[idx];
                end
                if ((q_ra2 != '0) && (addr_q[idx] == q_ra2)) begin
                    fwd2_hit  = 1'b1;
                    fwd2_data = data_q[idx];
                end
            end
        end
        pending[0] = 1'b0;
    end

endmodule
